// File: rtl/rv_div_pkg.sv
// Shared types and helpers for the RV32M divide unit: op encoding (funct3[1:0]),
// FSM state encoding and op classification.
package rv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_signed_op(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/rv_div_step.sv
// One restoring division iteration: shift in a dividend bit, subtract the divisor if it fits.
// Purely combinational; no handshake.
module rv_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  dividend_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  quot_bit
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // W+1 bits: the incoming remainder is < divisor, so the shifted value can need one more bit.
    assign shifted  = {rem_in, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quot_bit = (shifted >= {1'b0, divisor});
    assign rem_out  = quot_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/rv_div_unit.sv
// Radix-2 restoring DIV/DIVU/REM/REMU; DATA_WIDTH cycles accept-to-result, 1 cycle for div-by-zero/overflow.
// One op in flight: in_ready low until the result handshake; result held under out_ready backpressure.
module rv_div_unit
    import rv_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  div_op_e               Op,
    input  logic [DATA_WIDTH-1:0] Divident,
    input  logic [DATA_WIDTH-1:0] Divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Dbz
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    div_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    div_op_e        op_q;
    logic [W-1:0]   dvd_q;
    logic [W-1:0]   dvs_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic           sign_q_q;
    logic           sign_r_q;
    logic [W-1:0]   result_q;
    logic           dbz_q;

    logic           op_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           sovf;
    logic           special;
    logic [W-1:0]   spec_res;

    logic           calc;
    logic [W-1:0]   step_rem_in;
    logic           step_bit;
    logic [W-1:0]   step_dvs;
    logic [W-1:0]   step_rem_out;
    logic           step_qbit;

    logic [W-1:0]   quo_fin;
    logic [W-1:0]   res_quo;
    logic [W-1:0]   res_rem;
    logic [W-1:0]   fin_res;

    assign in_ready  = (state_q == IDLE) && !Rst && !flush;
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Dbz       = dbz_q;

    assign op_signed = is_signed_op(Op);
    assign a_neg     = op_signed && Divident[W-1];
    assign b_neg     = op_signed && Divisor[W-1];
    assign a_mag     = a_neg ? -Divident : Divident;
    assign b_mag     = b_neg ? -Divisor  : Divisor;
    assign div_zero  = (Divisor == '0);
    assign sovf      = op_signed && (Divident == MIN_VAL) && (Divisor == '1);
    assign special   = div_zero || sovf;

    always_comb begin
        spec_res = '0;
        if (is_rem_op(Op)) begin
            spec_res = div_zero ? Divident : '0;
        end else begin
            spec_res = div_zero ? '1 : MIN_VAL;
        end
    end

    // The first iteration runs on the accept edge straight from the operand magnitudes,
    // so the remaining W-1 iterations fit in CALC and the result lands W cycles after accept.
    assign calc        = (state_q == CALC);
    assign step_rem_in = calc ? rem_q      : '0;
    assign step_bit    = calc ? dvd_q[W-1] : a_mag[W-1];
    assign step_dvs    = calc ? dvs_q      : b_mag;

    rv_div_step #(
        .DATA_WIDTH(W)
    ) u_step (
        .rem_in       (step_rem_in),
        .dividend_bit (step_bit),
        .divisor      (step_dvs),
        .rem_out      (step_rem_out),
        .quot_bit     (step_qbit)
    );

    assign quo_fin = {quo_q[W-2:0], step_qbit};
    assign res_quo = sign_q_q ? -quo_fin      : quo_fin;
    assign res_rem = sign_r_q ? -step_rem_out : step_rem_out;
    assign fin_res = is_rem_op(op_q) ? res_rem : res_quo;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= DIVU;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= Op;
                        dbz_q    <= div_zero;
                        sign_q_q <= a_neg ^ b_neg;
                        sign_r_q <= a_neg;
                        dvs_q    <= b_mag;
                        if (special) begin
                            result_q <= spec_res;
                            state_q  <= DONE;
                        end else begin
                            rem_q   <= step_rem_out;
                            quo_q   <= {{(W-1){1'b0}}, step_qbit};
                            dvd_q   <= {a_mag[W-2:0], 1'b0};
                            cnt_q   <= CNT_W'(1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem_out;
                    quo_q <= quo_fin;
                    dvd_q <= {dvd_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        result_q <= fin_res;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_div_unit.sv
// Scoreboard bench for rv_div_unit at DATA_WIDTH=8: directed corner cases, backpressure,
// flush, reset-in-DONE, then randomized ops against an integer-arithmetic reference model.
module tb_rv_div_unit;
    import rv_div_pkg::*;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    div_op_e      Op;
    logic [W-1:0] Divident;
    logic [W-1:0] Divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Dbz;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bp_mode = 0;

    rv_div_unit #(.DATA_WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Op        (Op),
        .Divident  (Divident),
        .Divisor   (Divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Dbz       (Dbz)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: architectural RISC-V results from plain integer division (truncating).
    function automatic exp_t model(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
        int sa, sb, q, r;
        m.dbz = (b == 0);
        m.lat = W;
        m.acc_cyc = 0;
        q = 0;
        r = 0;
        if (b == 0) begin
            q = (1 << W) - 1;
            r = int'(a);
            m.lat = 1;
        end else if (op == DIV || op == REM) begin
            sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
            sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
            if (sa == -(1 << (W-1)) && sb == -1) begin
                q = sa;
                r = 0;
                m.lat = 1;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        m.res = (op == REM || op == REMU) ? W'(r) : W'(q);
        return m;
    endfunction

    // Present one op; on acceptance optionally push its expected response.
    task automatic send(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int t;
        exp_t e;
        @(negedge Clk);
        Op = op;
        Divident = a;
        Divisor = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end else if (push) begin
            e = model(op, a, b);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge Clk);
            t++;
        end
        check("wait_out_valid", longint'(out_valid), 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 400) begin
            @(negedge Clk);
            t++;
        end
        check("drain_done", longint'(t < 400), 1);
    endtask

    // out_ready driver, changed just after the rising edge so it is settled at the sample point.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks hold-stability while waiting and compares on every result handshake.
    initial begin
        bit           seen;
        int           first;
        logic [W-1:0] hold_res;
        logic         hold_dbz;
        exp_t         e;
        seen = 0;
        first = 0;
        hold_res = '0;
        hold_dbz = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                seen = 0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    first = cyc;
                    hold_res = Result;
                    hold_dbz = Dbz;
                end else begin
                    check("hold_result", longint'(Result), longint'(hold_res));
                    check("hold_dbz", longint'(Dbz), longint'(hold_dbz));
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got result 0x%0h with no op outstanding", Result);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", longint'(Result), longint'(e.res));
                        check("dbz", longint'(Dbz), longint'(e.dbz));
                        check("latency", longint'(first - e.acc_cyc), longint'(e.lat));
                    end
                    seen = 0;
                end
            end else begin
                seen = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    div_op_e      d_op[10] = '{DIVU, REMU, DIV, REM, DIV, REM, DIVU, REMU, DIV, REM};
    logic [W-1:0] d_a[10]  = '{8'h48, 8'h48, 8'hF9, 8'hF9, 8'h07, 8'hF9, 8'h2A, 8'h2A, 8'h80, 8'h80};
    logic [W-1:0] d_b[10]  = '{8'h18, 8'h18, 8'hFD, 8'hFD, 8'hFD, 8'h03, 8'h00, 8'h00, 8'hFF, 8'hFF};

    initial begin
        int hi_cnt;
        div_op_e      rop;
        logic [W-1:0] ra, rb;

        Rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        Op = DIVU;
        Divident = 8'd5;
        Divisor = 8'd1;
        repeat (3) @(negedge Clk);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_result", longint'(Result), 0);
        check("rst_dbz", longint'(Dbz), 0);
        Rst = 1'b0;
        in_valid = 1'b0;
        @(negedge Clk);
        check("post_rst_in_ready", longint'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            send(d_op[i], d_a[i], d_b[i], 1);
        end
        drain();

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        bp_mode = 1;
        @(negedge Clk);
        send(DIVU, 8'd100, 8'd5, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_in_ready", longint'(in_ready), 0);
        end
        bp_mode = 0;
        begin
            int t;
            t = 0;
            while (out_valid && t < 10) begin
                @(negedge Clk);
                t++;
            end
        end
        check("bp_release_in_ready", longint'(in_ready), 1);

        // Flush during CALC cycle 3: the op must vanish.
        send(DIV, 8'h9C, 8'h05, 0);
        repeat (2) @(negedge Clk);
        flush = 1'b1;
        #1;
        check("flush_in_ready", longint'(in_ready), 0);
        @(negedge Clk);
        flush = 1'b0;
        #1;
        check("post_flush_idle", longint'(in_ready), 1);
        hi_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge Clk);
            if (out_valid) hi_cnt++;
        end
        check("flush_no_valid", longint'(hi_cnt), 0);
        send(DIVU, 8'd200, 8'd7, 1);
        drain();

        // Reset while a result waits in DONE; a concurrent in_valid must not be accepted.
        bp_mode = 1;
        @(negedge Clk);
        send(DIVU, 8'h90, 8'h0C, 1);
        wait_valid();
        @(negedge Clk);
        Rst = 1'b1;
        in_valid = 1'b1;
        Op = REMU;
        Divident = 8'h33;
        Divisor = 8'h04;
        void'(sb_q.pop_front());
        #1;
        check("rst_done_in_ready", longint'(in_ready), 0);
        @(negedge Clk);
        check("rst_done_out_valid", longint'(out_valid), 0);
        check("rst_done_result", longint'(Result), 0);
        check("rst_done_dbz", longint'(Dbz), 0);
        Rst = 1'b0;
        in_valid = 1'b0;
        bp_mode = 0;
        @(negedge Clk);
        check("rst_done_not_accepted", longint'(in_ready), 1);
        check("rst_done_still_idle", longint'(out_valid), 0);

        // Randomized ops with random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            rop = div_op_e'(2'($urandom_range(0, 3)));
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 15))
                0, 1: rb = '0;
                2: begin ra = 8'h80; rb = 8'hFF; end
                3: rb = 8'h01;
                default: ;
            endcase
            send(rop, ra, rb, 1);
        end
        bp_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
